// File: rtl/commit_watchdog.sv
// Commit monitor and deadlock watchdog.
// Counts non-flushed retirements, keeps a ring buffer of recently committed
// PCs, and walks an IDLE/RUN/STALL/HUNG FSM driven by a no-progress counter.
module commit_watchdog #(
  parameter int NUM_COMMIT     = 2,
  parameter int PC_WIDTH       = 32,
  parameter int CNT_WIDTH      = 64,
  parameter int WARN_CYCLES    = 256,
  parameter int TIMEOUT_CYCLES = 2000,
  parameter int HIST_DEPTH     = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [PC_WIDTH-1:0]                 current_pc_i,
  input  logic [NUM_COMMIT-1:0]               commit_valid_i,
  input  logic [NUM_COMMIT-1:0]               commit_flushed_i,
  input  logic [NUM_COMMIT*PC_WIDTH-1:0]      commit_pc_i,
  input  logic                                clear_i,
  input  logic [$clog2(HIST_DEPTH)-1:0]       hist_rd_idx_i,
  output logic [PC_WIDTH-1:0]                 hist_rd_pc_o,
  output logic                                hist_rd_valid_o,
  output logic [CNT_WIDTH-1:0]                retired_count_o,
  output logic [$clog2(TIMEOUT_CYCLES+1)-1:0] stall_cnt_o,
  output logic [1:0]                          state_o,
  output logic                                stall_warn_o,
  output logic                                hang_o
);

  localparam int IDX_W = $clog2(HIST_DEPTH);
  localparam int HC_W  = IDX_W + 1;
  localparam int SC_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int NR_W  = $clog2(NUM_COMMIT + 1);
  localparam int SUM_W = HC_W + NR_W;

  localparam logic [SC_W-1:0]  WARN_S    = SC_W'(WARN_CYCLES);
  localparam logic [SC_W-1:0]  TIMEOUT_S = SC_W'(TIMEOUT_CYCLES);
  localparam logic [SUM_W-1:0] HIST_FULL = SUM_W'(HIST_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_HUNG  = 2'd3
  } state_t;

  // Number of set bits in the retire-event vector.
  function automatic logic [NR_W-1:0] popcount(input logic [NUM_COMMIT-1:0] vec);
    logic [NR_W-1:0] cnt;
    cnt = '0;
    for (int k = 0; k < NUM_COMMIT; k++) begin
      cnt = cnt + NR_W'(vec[k]);
    end
    return cnt;
  endfunction

  state_t               state_r;
  state_t               state_s;
  logic [CNT_WIDTH-1:0] retired_r;
  logic [SC_W-1:0]      stall_r;
  logic [SC_W-1:0]      stall_s;
  logic [PC_WIDTH-1:0]  pc_q_r;
  logic [IDX_W-1:0]     wr_ptr_r;
  logic [HC_W-1:0]      hist_cnt_r;
  logic [HC_W-1:0]      hist_cnt_s;
  logic [SUM_W-1:0]     hist_sum_s;
  logic                 warn_r;
  logic                 hang_r;
  logic [PC_WIDTH-1:0]  hist_mem [HIST_DEPTH];

  logic [NUM_COMMIT-1:0] ret_s;
  logic [NR_W-1:0]       n_ret_s;
  logic                  progress_s;
  logic                  update_s;
  logic [NR_W-1:0]       slot_s;
  logic [NUM_COMMIT-1:0] wr_en_s;
  logic [IDX_W-1:0]      wr_addr_s [NUM_COMMIT];
  logic [IDX_W-1:0]      rd_addr_s;
  logic                  rd_valid_s;

  // Retire events, progress detection, saturating stall count and history slots.
  always_comb begin
    ret_s      = commit_valid_i & ~commit_flushed_i;
    n_ret_s    = popcount(ret_s);
    progress_s = (n_ret_s != '0) || (current_pc_i != pc_q_r);
    update_s   = rst_n && !clear_i && (state_r != ST_HUNG);

    if (progress_s) begin
      stall_s = '0;
    end else if (stall_r == TIMEOUT_S) begin
      stall_s = stall_r;
    end else begin
      stall_s = stall_r + SC_W'(1);
    end

    hist_sum_s = SUM_W'(hist_cnt_r) + SUM_W'(n_ret_s);
    if (hist_sum_s > HIST_FULL) begin
      hist_cnt_s = HC_W'(HIST_DEPTH);
    end else begin
      hist_cnt_s = HC_W'(hist_sum_s);
    end

    // Events are packed in channel order; a later event lands in a later slot.
    slot_s = '0;
    for (int k = 0; k < NUM_COMMIT; k++) begin
      wr_addr_s[k] = wr_ptr_r + IDX_W'(slot_s);
      wr_en_s[k]   = ret_s[k] & update_s;
      slot_s       = slot_s + NR_W'(ret_s[k]);
    end
  end

  // Next-state logic; transitions are judged on the stall count of this edge.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (progress_s) begin
          state_s = ST_RUN;
        end else if (stall_s == TIMEOUT_S) begin
          state_s = ST_HUNG;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stall_s == WARN_S) begin
          state_s = ST_STALL;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_STALL: begin
        if (progress_s) begin
          state_s = ST_RUN;
        end else if (stall_s == TIMEOUT_S) begin
          state_s = ST_HUNG;
        end else begin
          state_s = ST_STALL;
        end
      end
      ST_HUNG: begin
        state_s = ST_HUNG;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Control state: reset/clear, frozen while hung, otherwise normal update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      retired_r  <= '0;
      stall_r    <= '0;
      pc_q_r     <= '0;
      wr_ptr_r   <= '0;
      hist_cnt_r <= '0;
      warn_r     <= 1'b0;
      hang_r     <= 1'b0;
    end else if (clear_i) begin
      state_r    <= ST_IDLE;
      retired_r  <= '0;
      stall_r    <= '0;
      pc_q_r     <= current_pc_i;
      wr_ptr_r   <= '0;
      hist_cnt_r <= '0;
      warn_r     <= 1'b0;
      hang_r     <= 1'b0;
    end else if (state_r == ST_HUNG) begin
      state_r    <= state_r;
      retired_r  <= retired_r;
      stall_r    <= stall_r;
      pc_q_r     <= pc_q_r;
      wr_ptr_r   <= wr_ptr_r;
      hist_cnt_r <= hist_cnt_r;
      warn_r     <= warn_r;
      hang_r     <= hang_r;
    end else begin
      state_r    <= state_s;
      retired_r  <= retired_r + CNT_WIDTH'(n_ret_s);
      stall_r    <= stall_s;
      pc_q_r     <= current_pc_i;
      wr_ptr_r   <= wr_ptr_r + IDX_W'(n_ret_s);
      hist_cnt_r <= hist_cnt_s;
      warn_r     <= (state_s == ST_STALL);
      hang_r     <= (state_s == ST_HUNG);
    end
  end

  // History storage; contents are masked by hist_cnt_r so no reset is needed.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_COMMIT; k++) begin
      if (wr_en_s[k]) begin
        hist_mem[wr_addr_s[k]] <= commit_pc_i[k*PC_WIDTH +: PC_WIDTH];
      end else begin
        hist_mem[wr_addr_s[k]] <= hist_mem[wr_addr_s[k]];
      end
    end
  end

  // History read port, index 0 is the newest entry.
  always_comb begin
    rd_addr_s  = wr_ptr_r - IDX_W'(1) - hist_rd_idx_i;
    rd_valid_s = (HC_W'(hist_rd_idx_i) < hist_cnt_r);
    if (rd_valid_s) begin
      hist_rd_pc_o = hist_mem[rd_addr_s];
    end else begin
      hist_rd_pc_o = '0;
    end
    hist_rd_valid_o = rd_valid_s;
  end

  assign retired_count_o = retired_r;
  assign stall_cnt_o     = stall_r;
  assign state_o         = state_r;
  assign stall_warn_o    = warn_r;
  assign hang_o          = hang_r;

endmodule

// File: doc/commit_watchdog.md
Name: commit_watchdog

Overview:
Synthesizable commit monitor and deadlock watchdog. It observes the processor's retire ports (NUM_COMMIT channels) and fetch PC, and counts non-flushed retirements. It keeps a ring buffer of the most recent committed PCs for post-mortem readout. It flags stall and hang conditions with programmable thresholds, so simulation and FPGA builds share one end-of-run and deadlock detector. It sits beside the retire stage in module_top and is read by the bench and debug logic.

Parameters:
NUM_COMMIT, 2, retire channels observed per cycle (1..4)
PC_WIDTH, 32, PC width
CNT_WIDTH, 64, retired-instruction counter width
WARN_CYCLES, 256, no-progress cycles before stall warning (must be < TIMEOUT_CYCLES)
TIMEOUT_CYCLES, 2000, no-progress cycles before hang
HIST_DEPTH, 8, committed-PC history entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
current_pc_i  in  PC_WIDTH  fetch PC
commit_valid_i  in  NUM_COMMIT  per-channel valid_commit
commit_flushed_i  in  NUM_COMMIT  per-channel flushed
commit_pc_i  in  NUM_COMMIT*PC_WIDTH  per-channel committed PC, channel 0 oldest
clear_i  in  1  soft clear of all state
hist_rd_idx_i  in  $clog2(HIST_DEPTH)  history read index, 0 = newest
hist_rd_pc_o  out  PC_WIDTH  history entry, combinational
hist_rd_valid_o  out  1  entry at index has been written
retired_count_o  out  CNT_WIDTH  non-flushed commits
stall_cnt_o  out  $clog2(TIMEOUT_CYCLES+1)  consecutive no-progress cycles
state_o  out  2  IDLE=0 RUN=1 STALL=2 HUNG=3
stall_warn_o  out  1  state==STALL
hang_o  out  1  state==HUNG

Behaviour:
- Reset (rst_n low at posedge): state IDLE; retired_count, stall_cnt, pc_q, wr_ptr and hist_count all 0. All outputs are therefore 0. History storage contents are don't-care, masked by hist_count.
- Retire event: channel k with commit_valid_i[k] & ~commit_flushed_i[k]. n_ret = popcount of retire events.
- Progress: n_ret > 0, or current_pc_i != pc_q.
- pc_q <= current_pc_i every cycle, except in HUNG.
- stall_cnt: cleared to 0 on progress. Otherwise it increments, saturating at TIMEOUT_CYCLES.
- retired_count += n_ret each cycle, wrapping modulo 2^CNT_WIDTH. Two commits in one cycle add 2.
- History write: retire events are packed in channel order. The j-th event (0-based) writes hist[(wr_ptr+j) mod HIST_DEPTH]. Then wr_ptr += n_ret (wrapping), and hist_count = min(hist_count+n_ret, HIST_DEPTH).
- History read: hist_rd_pc_o = hist[(wr_ptr-1-hist_rd_idx_i) mod HIST_DEPTH]. hist_rd_valid_o = hist_rd_idx_i < hist_count. hist_rd_pc_o = 0 when not valid.
- FSM, evaluated on the next-state stall count (S = value stall_cnt takes this edge):
  - IDLE: to RUN on progress. To HUNG if S == TIMEOUT_CYCLES. The warning is suppressed in IDLE to cover pipeline fill.
  - RUN: to STALL when S == WARN_CYCLES.
  - STALL: to RUN on progress. To HUNG when S == TIMEOUT_CYCLES.
  - HUNG: sticky, left only by clear_i or reset.
- Timing: stall_warn_o rises on the edge that completes exactly WARN_CYCLES consecutive no-progress cycles. hang_o rises on the edge that completes exactly TIMEOUT_CYCLES.
- In HUNG: commits and PC changes are ignored. retired_count, history, pc_q and stall_cnt are frozen for post-mortem.
- clear_i: same effect as reset except pc_q <= current_pc_i. clear_i has priority over any simultaneous commit or progress.
- Reset mid-operation: takes effect at that edge regardless of state. No partial history survives.

Test Plan:
1. Reset with commits active -> next cycle: state_o=0, retired_count_o=0, hist_rd_valid_o=0 for all indices.
2. NUM_COMMIT=2, one cycle with both channels valid, PCs 0x100/0x104 -> retired_count_o=2; idx0=0x104, idx1=0x100; state RUN.
3. Channel0 valid+flushed (0x200), channel1 valid (0x204) -> count +1; idx0=0x204; 0x200 is absent from history.
4. WARN=8, TIMEOUT=16, PC held with no commits from RUN -> stall_warn_o=1 after the 8th cycle. One commit at cycle 10 -> RUN, stall_cnt_o=0. Hold again -> hang_o=1 after exactly 16 further cycles.
5. HIST_DEPTH=8, 10 single commits with PCs 1..10 -> hist_count full; idx0=10, idx7=3; wr_ptr has wrapped.
6. In HUNG, apply commits and PC change -> count, history and hang_o unchanged. Then clear_i with a simultaneous commit -> IDLE, count 0, history empty.
